// File: rtl/cp_mode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp_mode_ctrl_if : register-block, buffer and AES-core bus for cp_mode_ctrl   |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
interface cp_mode_ctrl_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int SIZE_W = 12
);
   logic                   iStCp;
   logic [SIZE_W-1:0]      iCpByteSize;
   logic                   iMode;
   logic [DATA_W-1:0]      iIv;
   logic [DATA_W-1:0]      iAesKey;
   logic [ADDR_W-1:0]      iRdBase;
   logic [ADDR_W-1:0]      iWrBase;
   logic                   oRdEn_CpInBuf;
   logic [ADDR_W-1:0]      oRdAddr_CpInBuf;
   logic [DATA_W-1:0]      iRdDt_CpInBuf;
   logic                   oStAes;
   logic [DATA_W-1:0]      oAesKey;
   logic [DATA_W-1:0]      oPlainText;
   logic                   iAesDone;
   logic [DATA_W-1:0]      iCpText;
   logic                   oWrEn_CpOutBuf;
   logic [DATA_W/32-1:0]   oWdSel_CpOutBuf;
   logic [ADDR_W-1:0]      oWrAddr_CpOutBuf;
   logic [DATA_W-1:0]      oWrDt_CpOutBuf;
   logic                   oBusy;
   logic                   oCpDone;
`ifdef CP_ABORT_EN
   logic                   iAbort;
   logic                   oAborted;
`endif

   modport master (
`ifdef CP_ABORT_EN
      input  iAbort,
      output oAborted,
`endif
      input  iStCp, iCpByteSize, iMode, iIv, iAesKey, iRdBase, iWrBase,
      input  iRdDt_CpInBuf, iAesDone, iCpText,
      output oRdEn_CpInBuf, oRdAddr_CpInBuf, oStAes, oAesKey, oPlainText,
      output oWrEn_CpOutBuf, oWdSel_CpOutBuf, oWrAddr_CpOutBuf, oWrDt_CpOutBuf,
      output oBusy, oCpDone
   );

   modport slave (
`ifdef CP_ABORT_EN
      output iAbort,
      input  oAborted,
`endif
      output iStCp, iCpByteSize, iMode, iIv, iAesKey, iRdBase, iWrBase,
      output iRdDt_CpInBuf, iAesDone, iCpText,
      input  oRdEn_CpInBuf, oRdAddr_CpInBuf, oStAes, oAesKey, oPlainText,
      input  oWrEn_CpOutBuf, oWdSel_CpOutBuf, oWrAddr_CpOutBuf, oWrDt_CpOutBuf,
      input  oBusy, oCpDone
   );
endinterface
`default_nettype wire

// File: rtl/cp_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cp_mode_ctrl : ECB/CBC cipher sequencer between in-buffer, AES and out-buf   |
// | Optional abort port pair enabled by macro CP_ABORT_EN.  Revision 1.0         |
// +----------------------------------------------------------------------------+
module cp_mode_ctrl #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int SIZE_W = 12
) (
   input  logic            iClk,
   input  logic            iRsn,
   cp_mode_ctrl_if.master  bus
);
   localparam int WSEL_W  = DATA_W / 32;
   localparam int CNT_W   = ADDR_W + 1;
   localparam int MAX_BLK = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      RDW  = 3'd2,
      AES  = 3'd3,
      WR   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t              state, state_nxt;
   logic                mode, mode_nxt;
   logic [DATA_W-1:0]   chain, chain_nxt, key, key_nxt;
   logic [DATA_W-1:0]   plain, plain_nxt, wr_dt, wr_dt_nxt;
   logic [ADDR_W-1:0]   rd_base, rd_base_nxt, wr_base, wr_base_nxt;
   logic [ADDR_W-1:0]   rd_addr, rd_addr_nxt, wr_addr, wr_addr_nxt;
   logic [CNT_W-1:0]    count, count_nxt, idx, idx_nxt, blk_cnt;
   logic                rd_en, rd_en_nxt, st_aes, st_aes_nxt, wr_en, wr_en_nxt;
   logic [WSEL_W-1:0]   wdsel, wdsel_nxt;
   logic                busy, busy_nxt, cp_done, cp_done_nxt;
   logic                aborted, aborted_nxt, abort_req;
   logic [SIZE_W:0]     blk_raw;

   // Round the byte count up to whole blocks, then clamp to the buffer depth
   assign blk_raw = ({1'b0, bus.iCpByteSize} + (SIZE_W + 1)'(15)) >> 4;
   assign blk_cnt = (32'(blk_raw) > MAX_BLK) ? CNT_W'(MAX_BLK) : CNT_W'(blk_raw);

`ifdef CP_ABORT_EN
   assign abort_req    = bus.iAbort && (state != IDLE) && (state != DONE);
   assign bus.oAborted = aborted;
`else
   assign abort_req    = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      mode_nxt    = mode;
      chain_nxt   = chain;
      key_nxt     = key;
      plain_nxt   = plain;
      wr_dt_nxt   = wr_dt;
      rd_base_nxt = rd_base;
      wr_base_nxt = wr_base;
      count_nxt   = count;
      idx_nxt     = idx;
      aborted_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (bus.iStCp) begin
               mode_nxt    = bus.iMode;
               key_nxt     = bus.iAesKey;
               chain_nxt   = bus.iIv;
               rd_base_nxt = bus.iRdBase;
               wr_base_nxt = bus.iWrBase;
               count_nxt   = blk_cnt;
               idx_nxt     = '0;
               state_nxt   = (blk_cnt == '0) ? DONE : RD;
            end
         end
         RD:  state_nxt = RDW;
         RDW: begin
            plain_nxt = mode ? (bus.iRdDt_CpInBuf ^ chain) : bus.iRdDt_CpInBuf;
            state_nxt = AES;
         end
         AES: begin
            if (bus.iAesDone) begin
               wr_dt_nxt = bus.iCpText;
               if (mode) chain_nxt = bus.iCpText;
               state_nxt = WR;
            end
         end
         WR: begin
            idx_nxt   = idx + CNT_W'(1);
            state_nxt = (idx + CNT_W'(1) == count) ? DONE : RD;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Abort drops the pending block: the write data/chain updates above never reach a write
      if (abort_req) begin
         state_nxt   = DONE;
         aborted_nxt = 1'b1;
      end

      rd_en_nxt   = (state_nxt == RD);
      st_aes_nxt  = (state_nxt == AES) && (state != AES);
      wr_en_nxt   = (state_nxt == WR);
      wdsel_nxt   = {WSEL_W{state_nxt == WR}};
      busy_nxt    = (state_nxt == RD) || (state_nxt == RDW) ||
                    (state_nxt == AES) || (state_nxt == WR);
      cp_done_nxt = (state_nxt == DONE);
      rd_addr_nxt = (state_nxt == RD) ? rd_base_nxt + idx_nxt[ADDR_W-1:0] : rd_addr;
      wr_addr_nxt = (state_nxt == WR) ? wr_base + idx[ADDR_W-1:0] : wr_addr;
   end

   always_ff @(posedge iClk or negedge iRsn) begin
      if (!iRsn) begin
         state   <= IDLE;
         mode    <= 1'b0;
         chain   <= '0;
         key     <= '0;
         plain   <= '0;
         wr_dt   <= '0;
         rd_base <= '0;
         wr_base <= '0;
         rd_addr <= '0;
         wr_addr <= '0;
         count   <= '0;
         idx     <= '0;
         rd_en   <= 1'b0;
         st_aes  <= 1'b0;
         wr_en   <= 1'b0;
         wdsel   <= '0;
         busy    <= 1'b0;
         cp_done <= 1'b0;
         aborted <= 1'b0;
      end else begin
         state   <= state_nxt;
         mode    <= mode_nxt;
         chain   <= chain_nxt;
         key     <= key_nxt;
         plain   <= plain_nxt;
         wr_dt   <= wr_dt_nxt;
         rd_base <= rd_base_nxt;
         wr_base <= wr_base_nxt;
         rd_addr <= rd_addr_nxt;
         wr_addr <= wr_addr_nxt;
         count   <= count_nxt;
         idx     <= idx_nxt;
         rd_en   <= rd_en_nxt;
         st_aes  <= st_aes_nxt;
         wr_en   <= wr_en_nxt;
         wdsel   <= wdsel_nxt;
         busy    <= busy_nxt;
         cp_done <= cp_done_nxt;
         aborted <= aborted_nxt;
      end
   end

   assign bus.oRdEn_CpInBuf    = rd_en;
   assign bus.oRdAddr_CpInBuf  = rd_addr;
   assign bus.oStAes           = st_aes;
   assign bus.oAesKey          = key;
   assign bus.oPlainText       = plain;
   assign bus.oWrEn_CpOutBuf   = wr_en;
   assign bus.oWdSel_CpOutBuf  = wdsel;
   assign bus.oWrAddr_CpOutBuf = wr_addr;
   assign bus.oWrDt_CpOutBuf   = wr_dt;
   assign bus.oBusy            = busy;
   assign bus.oCpDone          = cp_done;
endmodule
`default_nettype wire

// File: tb/tb_cp_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cp_mode_ctrl : directed self-checking bench for cp_mode_ctrl              |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
module tb_cp_mode_ctrl;
   localparam int DATA_W = 128;
   localparam int ADDR_W = 7;
   localparam int SIZE_W = 12;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] P3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
   localparam logic [127:0] C1  = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] C2  = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] C3  = 128'h73bed6b8e3c1743b7116e69e22229516;
   localparam logic [127:0] KEY_A = 128'hdeadbeef_01234567_89abcdef_cafef00d;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cp_mode_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) bus ();
   cp_mode_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) dut (
      .iClk (clk),
      .iRsn (rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int failures = 0;

   logic [127:0] mem [128];
   logic         prev_en = 1'b0;
   logic [6:0]   prev_addr = '0;
   int           aes_cnt = 0;
   int           cyc = 0;
   int           st_cnt = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0, bad_wsel = 0;
   int           last_wr_cyc = 0, done_cyc = 0;
   logic [6:0]   rd_log[$], wr_addr_log[$];
   logic [127:0] wr_dt_log[$], pt_log[$];

   // Stand-in cipher: the real NIST CBC pairs, otherwise a simple keyless permutation
   function automatic logic [127:0] aes_stub(input logic [127:0] pt);
      if (pt === (P1 ^ IV)) return C1;
      if (pt === (P2 ^ C1)) return C2;
      if (pt === (P3 ^ C2)) return C3;
      return {pt[95:0], pt[127:96]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
   endfunction

   // Input buffer (1-cycle read), AES core (9-cycle latency) and bus monitor
   always @(negedge clk) begin
      cyc++;
      bus.iRdDt_CpInBuf = prev_en ? mem[prev_addr] : 'x;
      prev_en   = bus.oRdEn_CpInBuf;
      prev_addr = bus.oRdAddr_CpInBuf;
      bus.iAesDone = 1'b0;
      bus.iCpText  = 'x;
      if (bus.oStAes) begin
         aes_cnt = 9;
         st_cnt++;
         pt_log.push_back(bus.oPlainText);
      end else if (aes_cnt > 1) begin
         aes_cnt--;
      end else if (aes_cnt == 1) begin
         aes_cnt = 0;
         bus.iAesDone = 1'b1;
         bus.iCpText  = aes_stub(bus.oPlainText);
      end
      if (bus.oRdEn_CpInBuf) begin
         rd_cnt++;
         rd_log.push_back(bus.oRdAddr_CpInBuf);
      end
      if (bus.oWrEn_CpOutBuf) begin
         wr_cnt++;
         wr_addr_log.push_back(bus.oWrAddr_CpOutBuf);
         wr_dt_log.push_back(bus.oWrDt_CpOutBuf);
         last_wr_cyc = cyc;
         if (bus.oWdSel_CpOutBuf !== 4'hF) bad_wsel++;
      end
      if (bus.oCpDone) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic m, input int size, input logic [6:0] rdb,
                        input logic [6:0] wrb, input logic [127:0] iv, input logic [127:0] k);
      bus.iMode       = m;
      bus.iCpByteSize = SIZE_W'(size);
      bus.iRdBase     = rdb;
      bus.iWrBase     = wrb;
      bus.iIv         = iv;
      bus.iAesKey     = k;
      bus.iStCp       = 1'b1;
      tick();
      bus.iStCp       = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < limit && !seen; i++) begin
         tick();
         if (bus.oCpDone === 1'b1) seen = 1'b1;
      end
      check(tag, seen, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st0, rd0, wr0, dn0, wq, pq, rq;
      for (int i = 0; i < 128; i++)
         mem[i] = {32'h1000_0000 + 32'(i), 32'ha5a5_0000 + 32'(i), ~32'(i), 32'(i * 3)};
      mem[32] = P1;
      mem[33] = P2;
      mem[34] = P3;
      bus.iStCp = 1'b0;
      bus.iCpByteSize = '0;
      bus.iMode = 1'b0;
      bus.iIv = '0;
      bus.iAesKey = '0;
      bus.iRdBase = '0;
      bus.iWrBase = '0;
`ifdef CP_ABORT_EN
      bus.iAbort = 1'b0;
`endif
      repeat (3) tick();
      check("rst_busy",  bus.oBusy, 0);
      check("rst_done",  bus.oCpDone, 0);
      check("rst_rden",  bus.oRdEn_CpInBuf, 0);
      check("rst_staes", bus.oStAes, 0);
      check("rst_wren",  bus.oWrEn_CpOutBuf, 0);
      check("rst_wdsel", bus.oWdSel_CpOutBuf, 0);
      check("rst_addr",  {bus.oRdAddr_CpInBuf, bus.oWrAddr_CpOutBuf}, 0);
      check("rst_data",  bus.oWrDt_CpOutBuf | bus.oAesKey | bus.oPlainText, 0);
      rst_n = 1'b1;
      tick();

      // ECB, 32 bytes, rdBase 0, wrBase 0x10
      st0 = st_cnt; wr0 = wr_cnt; wq = wr_dt_log.size();
      start(1'b0, 32, 7'h00, 7'h10, 128'h0, KEY_A);
      check("ecb_busy_after_start", bus.oBusy, 1);
      check("ecb_key", bus.oAesKey, KEY_A);
      wait_done("ecb_done", 200);
      check("ecb_busy_at_done", bus.oBusy, 0);
      tick();
      check("ecb_done_pulse", bus.oCpDone, 0);
      check("ecb_staes_cnt", st_cnt - st0, 2);
      check("ecb_wr_cnt", wr_cnt - wr0, 2);
      check("ecb_wa0", wr_addr_log[wq], 7'h10);
      check("ecb_wa1", wr_addr_log[wq + 1], 7'h11);
      check("ecb_wd0", wr_dt_log[wq], aes_stub(mem[0]));
      check("ecb_wd1", wr_dt_log[wq + 1], aes_stub(mem[1]));
      check("ecb_done_latency", done_cyc, last_wr_cyc + 1);
      check("ecb_wdsel", bad_wsel, 0);

      // CBC, 48 bytes, NIST SP800-38A vectors
      wq = wr_dt_log.size(); pq = pt_log.size();
      start(1'b1, 48, 7'h20, 7'h30, IV, KEY);
      wait_done("cbc_done", 300);
      tick();
      check("cbc_pt0", pt_log[pq],     P1 ^ IV);
      check("cbc_pt1", pt_log[pq + 1], P2 ^ C1);
      check("cbc_pt2", pt_log[pq + 2], P3 ^ C2);
      check("cbc_c0", wr_dt_log[wq],     C1);
      check("cbc_c1", wr_dt_log[wq + 1], C2);
      check("cbc_c2", wr_dt_log[wq + 2], C3);
      check("cbc_wa2", wr_addr_log[wq + 2], 7'h32);
      check("cbc_key", bus.oAesKey, KEY);

      // Zero bytes: done one cycle after start, no accesses
      st0 = st_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
      start(1'b0, 0, 7'h00, 7'h00, 128'h0, KEY_A);
      check("zero_done", bus.oCpDone, 1);
      check("zero_busy", bus.oBusy, 0);
      repeat (5) tick();
      check("zero_no_access", {32'(st_cnt - st0), 32'(rd_cnt - rd0), 32'(wr_cnt - wr0)}, 0);

      // 17 bytes -> 2 blocks, base 0x7F wraps to 0x00
      st0 = st_cnt; wq = wr_dt_log.size(); rq = rd_log.size();
      start(1'b0, 17, 7'h7f, 7'h7f, 128'h0, KEY_A);
      wait_done("wrap_done", 200);
      tick();
      check("wrap_blocks", st_cnt - st0, 2);
      check("wrap_ra0", rd_log[rq],     7'h7f);
      check("wrap_ra1", rd_log[rq + 1], 7'h00);
      check("wrap_wa1", wr_addr_log[wq + 1], 7'h00);
      check("wrap_wd0", wr_dt_log[wq],     aes_stub(mem[127]));
      check("wrap_wd1", wr_dt_log[wq + 1], aes_stub(mem[0]));

      // Start re-pulsed while busy is ignored
      wr0 = wr_cnt; dn0 = done_cnt;
      start(1'b0, 16, 7'h03, 7'h40, 128'h0, KEY_A);
      repeat (3) tick();
      start(1'b0, 64, 7'h08, 7'h50, 128'h0, KEY_A);
      wait_done("restart_done", 200);
      repeat (30) tick();
      check("restart_wr_cnt", wr_cnt - wr0, 1);
      check("restart_done_cnt", done_cnt - dn0, 1);
      check("restart_wa", wr_addr_log[wr_addr_log.size() - 1], 7'h40);

      // Reset during block-1 AES wait
      st0 = st_cnt; wr0 = wr_cnt; dn0 = done_cnt;
      start(1'b0, 32, 7'h00, 7'h10, 128'h0, KEY_A);
      for (int i = 0; i < 100 && (st_cnt - st0) < 2; i++) tick();
      check("rst_mid_reached_blk1", st_cnt - st0, 2);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", bus.oBusy, 0);
      check("rst_mid_data", bus.oAesKey | bus.oPlainText | bus.oWrDt_CpOutBuf, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (25) tick();
      check("rst_mid_no_done", done_cnt - dn0, 0);
      check("rst_mid_wr_cnt", wr_cnt - wr0, 1);
      wq = wr_dt_log.size();
      start(1'b0, 16, 7'h05, 7'h06, 128'h0, KEY_A);
      wait_done("rst_fresh_done", 200);
      tick();
      check("rst_fresh_wa", wr_addr_log[wq], 7'h06);
      check("rst_fresh_wd", wr_dt_log[wq], aes_stub(mem[5]));

`ifdef CP_ABORT_EN
      // Abort during block-0 AES wait
      st0 = st_cnt; wr0 = wr_cnt; dn0 = done_cnt;
      start(1'b0, 32, 7'h00, 7'h10, 128'h0, KEY_A);
      for (int i = 0; i < 20 && (st_cnt - st0) < 1; i++) tick();
      repeat (2) tick();
      bus.iAbort = 1'b1;
      tick();
      bus.iAbort = 1'b0;
      check("abort_done", bus.oCpDone, 1);
      check("abort_flag", bus.oAborted, 1);
      repeat (20) tick();
      check("abort_no_write", wr_cnt - wr0, 0);
      check("abort_done_cnt", done_cnt - dn0, 1);
      bus.iAbort = 1'b1;
      tick();
      bus.iAbort = 1'b0;
      check("abort_idle", {bus.oCpDone, bus.oAborted}, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
